// File: rtl/std_reg_pkg.sv
// Shared constants for the standard register family: the widest supported
// word and the bit positions inside the err status vector.
package std_reg_pkg;

    localparam int MAX_REG_WIDTH = 256;
    localparam int ERR_OVF       = 0;
    localparam int ERR_UNF       = 1;

endpackage : std_reg_pkg

// File: rtl/std_reg_queue_ptr.sv
// Wrapping index counter for std_reg_queue. Counts 0 .. DEPTH-1 and wraps
// back to 0 with an explicit compare, so DEPTH need not be a power of two.
module std_reg_queue_ptr #(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next index: advance on inc, wrap from the last entry back to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == LAST_IDX) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Index register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : std_reg_queue_ptr

// File: rtl/std_reg_queue.sv
// std_reg_queue: DEPTH-entry queue of STORAGE_WIDTH-bit words with a
// load/read handshake, full/empty/count status and a head output that is
// zero-extended or truncated to OUTPUT_WIDTH (0 while empty).
// Optional feature macro: STD_REG_QUEUE_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags on err; without it err is constant 2'b00.
// WORD_WIDTH defaults to 16 when not supplied by the build.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module std_reg_queue
    import std_reg_pkg::*;
#(
    parameter int  STORAGE_WIDTH = `WORD_WIDTH,
    parameter int  OUTPUT_WIDTH  = `WORD_WIDTH,
    parameter int  DEPTH         = 4,
    localparam int CW            = $clog2(DEPTH + 1),
    localparam int PW            = $clog2(DEPTH)
) (
    input  logic                     sysclk,
    input  logic                     sysreset_n,
    input  logic [STORAGE_WIDTH-1:0] data_in,
    input  logic                     load,
    input  logic                     read,
    output logic [OUTPUT_WIDTH-1:0]  data_out,
    output logic                     full,
    output logic                     empty,
    output logic [CW-1:0]            count,
    output logic [1:0]               err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [STORAGE_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic [PW-1:0]            wr_ptr_s;
    logic [PW-1:0]            rd_ptr_s;
    logic                     full_s;
    logic                     empty_s;
    logic                     push_s;
    logic                     pop_s;
    logic [STORAGE_WIDTH-1:0] head_s;
    logic [OUTPUT_WIDTH-1:0]  head_fit_s;

    // Handshake decode: a full queue still accepts a load when the same
    // edge pops; an empty queue never pops, even alongside a load.
    always_comb begin
        full_s  = (count_q == DEPTH_C);
        empty_s = (count_q == {CW{1'b0}});
        push_s  = load && (!full_s || read);
        pop_s   = read && !empty_s;
    end

    // Occupancy update: a push and a pop on the same edge cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register; a reset discards whatever the queue held.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Storage array is intentionally not reset; the output gate hides it.
    always_ff @(posedge sysclk) begin
        if (push_s) begin
            mem_q[wr_ptr_s] <= data_in;
        end
    end

    std_reg_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (sysclk),
        .rst_n (sysreset_n),
        .inc   (push_s),
        .ptr   (wr_ptr_s)
    );

    std_reg_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (sysclk),
        .rst_n (sysreset_n),
        .inc   (pop_s),
        .ptr   (rd_ptr_s)
    );

    assign head_s = mem_q[rd_ptr_s];

    generate
        if (OUTPUT_WIDTH > STORAGE_WIDTH) begin : g_pad
            assign head_fit_s = {{(OUTPUT_WIDTH - STORAGE_WIDTH){1'b0}}, head_s};
        end else begin : g_trunc
            assign head_fit_s = head_s[OUTPUT_WIDTH-1:0];
        end
    endgenerate

    // Head output, forced to zero while the queue is empty.
    always_comb begin
        if (empty_s) begin
            data_out = {OUTPUT_WIDTH{1'b0}};
        end else begin
            data_out = head_fit_s;
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_q;

`ifdef STD_REG_QUEUE_ERR_FLAGS_EN
    logic [1:0] err_q;
    logic [1:0] err_d;

    // Sticky flags: dropped load while full, read while empty.
    always_comb begin
        err_d = err_q;
        if (load && full_s && !read) begin
            err_d[ERR_OVF] = 1'b1;
        end else begin
            err_d[ERR_OVF] = err_q[ERR_OVF];
        end
        if (read && empty_s) begin
            err_d[ERR_UNF] = 1'b1;
        end else begin
            err_d[ERR_UNF] = err_q[ERR_UNF];
        end
    end

    // Flag register, cleared only by reset.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule : std_reg_queue

// File: tb/tb_std_reg_queue.sv
// Scoreboard bench for std_reg_queue: instance A (DEPTH=4, 16/16) and
// instance B (DEPTH=3, storage 8, output 16). Expected words are queued
// when a push is accepted and compared against data_out when popped.
module tb_std_reg_queue;

    logic        clk;
    logic        rst_n;

    logic [15:0] data_in_a;
    logic        load_a;
    logic        read_a;
    logic [15:0] data_out_a;
    logic        full_a;
    logic        empty_a;
    logic [2:0]  count_a;
    logic [1:0]  err_a;

    logic [7:0]  data_in_b;
    logic        load_b;
    logic        read_b;
    logic [15:0] data_out_b;
    logic        full_b;
    logic        empty_b;
    logic [1:0]  count_b;
    logic [1:0]  err_b;

    int n_cmp;
    int n_bad;

    logic [15:0] sb_a[$];
    logic [7:0]  sb_b[$];
    logic [1:0]  exp_err_a;
    logic [1:0]  exp_err_b;

    std_reg_queue #(.STORAGE_WIDTH(16), .OUTPUT_WIDTH(16), .DEPTH(4)) u_dut_a (
        .sysclk     (clk),
        .sysreset_n (rst_n),
        .data_in    (data_in_a),
        .load       (load_a),
        .read       (read_a),
        .data_out   (data_out_a),
        .full       (full_a),
        .empty      (empty_a),
        .count      (count_a),
        .err        (err_a)
    );

    std_reg_queue #(.STORAGE_WIDTH(8), .OUTPUT_WIDTH(16), .DEPTH(3)) u_dut_b (
        .sysclk     (clk),
        .sysreset_n (rst_n),
        .data_in    (data_in_b),
        .load       (load_b),
        .read       (read_b),
        .data_out   (data_out_b),
        .full       (full_b),
        .empty      (empty_b),
        .count      (count_b),
        .err        (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] err_expect(input logic [1:0] e);
`ifdef STD_REG_QUEUE_ERR_FLAGS_EN
        return e;
`else
        return 2'b00;
`endif
    endfunction

    // One cycle on instance A: check state at negedge, update model, drive, clock.
    task automatic step_a(input logic l, input logic r, input logic [15:0] d);
        int sz;
        logic [15:0] w;
        sz = sb_a.size();
        check_val("a_count", 32'(count_a), 32'(sz));
        check_val("a_full",  32'(full_a),  32'(sz == 4));
        check_val("a_empty", 32'(empty_a), 32'(sz == 0));
        check_val("a_err",   32'(err_a),   32'(err_expect(exp_err_a)));
        if (sz == 0) begin
            check_val("a_head_empty", 32'(data_out_a), 32'h0);
        end
        if (l && sz == 4 && !r) exp_err_a[0] = 1'b1;
        if (r && sz == 0)       exp_err_a[1] = 1'b1;
        if (r && sz > 0) begin
            w = sb_a.pop_front();
            check_val("a_pop", 32'(data_out_a), 32'(w));
        end
        if (l && (sz < 4 || r)) sb_a.push_back(d);
        load_a = l; read_a = r; data_in_a = d;
        @(posedge clk);
        @(negedge clk);
        load_a = 1'b0; read_a = 1'b0;
    endtask

    // One cycle on instance B; output must be the 8-bit head zero-extended.
    task automatic step_b(input logic l, input logic r, input logic [7:0] d);
        int sz;
        logic [7:0] w;
        sz = sb_b.size();
        check_val("b_count", 32'(count_b), 32'(sz));
        check_val("b_full",  32'(full_b),  32'(sz == 3));
        check_val("b_empty", 32'(empty_b), 32'(sz == 0));
        check_val("b_err",   32'(err_b),   32'(err_expect(exp_err_b)));
        if (sz == 0) begin
            check_val("b_head_empty", 32'(data_out_b), 32'h0);
        end
        if (l && sz == 3 && !r) exp_err_b[0] = 1'b1;
        if (r && sz == 0)       exp_err_b[1] = 1'b1;
        if (r && sz > 0) begin
            w = sb_b.pop_front();
            check_val("b_pop", 32'(data_out_b), {16'h0, 8'h00, w});
        end
        if (l && (sz < 3 || r)) sb_b.push_back(d);
        load_b = l; read_b = r; data_in_b = d;
        @(posedge clk);
        @(negedge clk);
        load_b = 1'b0; read_b = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        exp_err_a = 2'b00; exp_err_b = 2'b00;
        load_a = 1'b0; read_a = 1'b0; data_in_a = 16'h0000;
        load_b = 1'b0; read_b = 1'b0; data_in_b = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_count", 32'(count_a), 32'h0);
        check_val("rst_empty", 32'(empty_a), 32'h1);
        check_val("rst_full",  32'(full_a),  32'h0);
        check_val("rst_dout",  32'(data_out_a), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill to full, then drain in order.
        step_a(1'b1, 1'b0, 16'h1111);
        step_a(1'b1, 1'b0, 16'h2222);
        step_a(1'b1, 1'b0, 16'h3333);
        step_a(1'b1, 1'b0, 16'h4444);
        check_val("a_head_full", 32'(data_out_a), 32'h1111);
        // Dropped load while full.
        step_a(1'b1, 1'b0, 16'h5555);
        check_val("a_head_after_drop", 32'(data_out_a), 32'h1111);
        // Load+read while full: both accepted.
        step_a(1'b1, 1'b1, 16'h6666);
        check_val("a_head_advance", 32'(data_out_a), 32'h2222);
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, 16'h0000);
        step_a(1'b0, 1'b0, 16'h0000);
        // Load+read while empty: push only.
        step_a(1'b1, 1'b1, 16'hABCD);
        check_val("a_head_abcd", 32'(data_out_a), 32'hABCD);
        step_a(1'b0, 1'b1, 16'h0000);
        step_a(1'b0, 1'b1, 16'h0000);
        step_a(1'b0, 1'b0, 16'h0000);

        // Asynchronous reset between edges with two entries held.
        step_a(1'b1, 1'b0, 16'h0A0A);
        step_a(1'b1, 1'b0, 16'h0B0B);
        check_val("a_pre_rst_count", 32'(count_a), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_count", 32'(count_a), 32'h0);
        check_val("mid_rst_empty", 32'(empty_a), 32'h1);
        check_val("mid_rst_dout",  32'(data_out_a), 32'h0);
        check_val("mid_rst_err",   32'(err_a), 32'h0);
        sb_a.delete();
        exp_err_a = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b0, 1'b0, 16'h0000);
        step_a(1'b1, 1'b0, 16'h7777);
        step_a(1'b0, 1'b1, 16'h0000);
        step_a(1'b0, 1'b0, 16'h0000);

        // Instance B: push/pop pairs across the 2 -> 0 wrap, then full churn.
        for (int i = 0; i < 10; i++) begin
            step_b(1'b1, 1'b0, 8'(8'hA0 + i));
            step_b(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 3; i++) step_b(1'b1, 1'b0, 8'(8'hC0 + i));
        check_val("b_head_pad", 32'(data_out_b), 32'h00C0);
        for (int i = 0; i < 5; i++) step_b(1'b1, 1'b1, 8'(8'hD0 + i));
        for (int i = 0; i < 3; i++) step_b(1'b0, 1'b1, 8'h00);
        step_b(1'b0, 1'b0, 8'h00);
        check_val("a_sb_drained", 32'(sb_a.size()), 32'h0);
        check_val("b_sb_drained", 32'(sb_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_std_reg_queue
